cpu_step_ctrl: RTL
==================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 1000000, is the number of consecutive stable CLK cycles needed to accept a Button level change (10 ms at 100 MHz).
REQ-002 Parameter RUN_DIV, default 50000000, is the CLK-cycle period of cpu_en pulses in continuous-run mode.
REQ-003 Parameter RST_LEN, default 4, is the number of CLK cycles cpu_rst is held high per CPU restart.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Button  input  1  raw push-button, asynchronous to CLK, bouncing.
REQ-007 Mode  input  1  0 = single-step, 1 = continuous run.
REQ-008 Halt  input  1  CPU reports a halt instruction executed, level.
REQ-009 cpu_en  output  1  registered one-cycle clock enable to CPU PC/register file/memory writes.
REQ-010 cpu_rst  output  1  registered reset to CPU datapath, active-high.
REQ-011 step_cnt  output  16  count of cpu_en pulses issued since last CPU restart.
REQ-012 state  output  3  current FSM state: RST=0, IDLE=1, STEP=2, RUN=3, HALT=4.

Function
REQ-013 Button SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Debounced level SHALL change only after the synchronized input has differed from it for DEB_CNT consecutive cycles; any agreement clears the counter.
REQ-015 A press event SHALL be a single-cycle pulse on the cycle the debounced level rises 0->1; release generates no event.
REQ-016 RST: cpu_rst=1, cpu_en=0, step_cnt=0; after RST_LEN cycles in RST -> IDLE with cpu_rst=0.
REQ-017 IDLE: Halt=1 -> HALT (priority); else press with Mode=0 -> STEP; press with Mode=1 -> RUN with run divider cleared.
REQ-018 STEP: cpu_en=1 for exactly this one cycle, step_cnt increments; next state IDLE.
REQ-019 RUN: divider counts 0..RUN_DIV-1 and wraps; cpu_en=1 only on the cycle divider equals RUN_DIV-1; first pulse is RUN_DIV cycles after entry.
REQ-020 RUN exit: Halt=1 -> HALT; else press or Mode=0 -> IDLE; any exit cycle issues no cpu_en.
REQ-021 Halt coinciding with a divider terminal count SHALL suppress that cpu_en pulse.
REQ-022 HALT: cpu_en=0; press -> RST (CPU restart); Mode changes ignored.
REQ-023 Every cpu_en pulse SHALL increment step_cnt in the same cycle; step_cnt saturates at 16'hFFFF.
REQ-024 Mode SHALL be sampled only in IDLE and RUN; changes during STEP/RST/HALT have no effect.
REQ-025 Press latency: debounced rise at cycle N -> state change registered at N+1, cpu_en high at N+1 for STEP.
REQ-026 No more than one press event SHALL be recognized per debounced rise, however long Button is held.

Reset
REQ-027 Reset=1 on any rising edge SHALL force state=RST, cpu_rst=1, cpu_en=0, step_cnt=0, debounce counter=0, debounced level=0, synchronizer=0, divider=0, RST_LEN counter=0.
REQ-028 Reset asserted mid-STEP or mid-RUN SHALL drop cpu_en on the next edge, with no further pulse until a new press after reset.
REQ-029 A Button held high through reset release SHALL produce one press event after DEB_CNT stable cycles.

Verification (DEB_CNT=4, RUN_DIV=8, RST_LEN=4)
REQ-030 Reset 2 cycles then release -> cpu_rst high exactly 4 cycles after release, state 0->1, cpu_en never high.
REQ-031 Mode=0, Button bounces 1-0-1 at 1-cycle intervals then held high 10 cycles -> exactly one cpu_en pulse, step_cnt=1, state returns to 1.
REQ-032 Mode=1, clean press -> cpu_en pulses every 8 cycles, first at cycle 8 after RUN entry; second press after 3 pulses -> state=1, step_cnt=3.
REQ-033 In RUN, Halt=1 on a terminal-count cycle -> no cpu_en that cycle, state=4; press -> cpu_rst for 4 cycles, step_cnt=0, state=1.
REQ-034 Preload step_cnt to 16'hFFFE via 2 further steps beyond 16'hFFFF -> holds at 16'hFFFF.
REQ-035 Reset asserted on the cycle cpu_en is high in RUN -> cpu_en=0 next cycle, state=0, step_cnt=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Single-step / continuous-run controller for a teaching CPU: it debounces a push-button
// and turns presses into cpu_en clock enables, with halt handling and a CPU restart sequence.
module cpu_step_ctrl #(
  parameter int DEB_CNT = 1000000,
  parameter int RUN_DIV = 50000000,
  parameter int RST_LEN = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Button,
  input  logic        Mode,
  input  logic        Halt,
  output logic        cpu_en,
  output logic        cpu_rst,
  output logic [15:0] step_cnt,
  output logic [2:0]  state
);
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int VW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

  typedef enum logic [2:0] {
    RST  = 3'd0,
    IDLE = 3'd1,
    STEP = 3'd2,
    RUN  = 3'd3,
    HALT = 3'd4
  } st_t;

  st_t           cur, nxt;
  logic [1:0]    sync;
  logic          deb_lvl, deb_d;
  logic [DW-1:0] deb_cnt;
  logic [VW-1:0] div, div_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          en_nxt;
  logic          press;

  // One-cycle event on the debounced rising edge; release is ignored.
  assign press = deb_lvl & ~deb_d;
  assign state = cur;

  always_comb begin
    nxt      = cur;
    div_nxt  = div;
    rcnt_nxt = rcnt;
    en_nxt   = 1'b0;
    case (cur)
      RST:
        if (rcnt == RW'(RST_LEN - 1)) nxt = IDLE;
        else rcnt_nxt = rcnt + 1'b1;
      IDLE:
        if (Halt) nxt = HALT;
        else if (press) begin
          nxt     = Mode ? RUN : STEP;
          en_nxt  = ~Mode;
          div_nxt = '0;
        end
      STEP: nxt = IDLE;
      RUN:
        // Exits win over the terminal count, so a leaving cycle never pulses.
        if (Halt) nxt = HALT;
        else if (press || !Mode) nxt = IDLE;
        else if (div == VW'(RUN_DIV - 1)) begin
          div_nxt = '0;
          en_nxt  = 1'b1;
        end else div_nxt = div + 1'b1;
      HALT:
        if (press) begin
          nxt      = RST;
          rcnt_nxt = '0;
        end
      default: nxt = RST;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync     <= '0;
      deb_lvl  <= 1'b0;
      deb_d    <= 1'b0;
      deb_cnt  <= '0;
      cur      <= RST;
      div      <= '0;
      rcnt     <= '0;
      cpu_en   <= 1'b0;
      cpu_rst  <= 1'b1;
      step_cnt <= '0;
    end else begin
      sync  <= {sync[0], Button};
      deb_d <= deb_lvl;
      if (sync[1] == deb_lvl) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB_CNT - 1)) begin
        deb_cnt <= '0;
        deb_lvl <= sync[1];
      end else deb_cnt <= deb_cnt + 1'b1;
      cur     <= nxt;
      div     <= div_nxt;
      rcnt    <= rcnt_nxt;
      cpu_en  <= en_nxt;
      cpu_rst <= (nxt == RST);
      if (nxt == RST) step_cnt <= '0;
      else if (en_nxt && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 1'b1;
    end
  end
endmodule
